// File: rtl/stack_ctrl.sv
// Downward-growing hardware stack controller driving an external synchronous RAM.
// Push takes two cycles accept-to-ready; pop takes three and ends in a pop_valid pulse.
module stack_ctrl #(
  parameter logic [15:0] STACK_TOP = 16'h01FF,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_req,
  input  logic [15:0] push_data,
  input  logic        pop_req,
  input  logic        clr_err,
  output logic        ready,
  output logic [15:0] pop_data,
  output logic        pop_valid,
  output logic [15:0] sp,
  output logic [8:0]  count,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic        underflow,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [1:0] {IDLE, PUSH, POP_RD, POP_CAP} state_t;

  state_t      state_reg, state_next;
  logic        ready_reg;
  logic [15:0] sp_reg;
  logic [15:0] data_reg;
  logic [15:0] pop_data_reg;
  logic        pop_valid_reg;
  logic        overflow_reg, underflow_reg;
  logic [15:0] used;
  logic        is_full, is_empty;
  logic        idle_ok, push_ok, pop_ok, ovf_set, unf_set;

  assign used     = STACK_TOP - sp_reg;
  assign is_full  = (used == DEPTH_W);
  assign is_empty = (used == 16'h0000);

  // ready is registered so it rises only on the first edge after reset release.
  assign idle_ok = ready_reg && (state_reg == IDLE);
  assign push_ok = idle_ok && push_req && !is_full;
  assign pop_ok  = idle_ok && pop_req && !is_empty && !push_ok;
  assign ovf_set = idle_ok && push_req && is_full && !pop_req;
  assign unf_set = idle_ok && pop_req && is_empty && !push_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b0;
      sp_reg        <= STACK_TOP;
      data_reg      <= 16'h0000;
      pop_data_reg  <= 16'h0000;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ready_reg     <= (state_next == IDLE);
      pop_valid_reg <= (state_reg == POP_CAP);
      if (push_ok)
        data_reg <= push_data;
      if (state_reg == PUSH)
        sp_reg <= sp_reg - 16'h0001;
      else if (pop_ok)
        sp_reg <= sp_reg + 16'h0001;
      if (state_reg == POP_CAP)
        pop_data_reg <= mem_rdata;
      // A new error in the same cycle as clr_err keeps the flag set.
      if (ovf_set)
        overflow_reg <= 1'b1;
      else if (clr_err)
        overflow_reg <= 1'b0;
      if (unf_set)
        underflow_reg <= 1'b1;
      else if (clr_err)
        underflow_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (push_ok)
          state_next = PUSH;
        else if (pop_ok)
          state_next = POP_RD;
      end
      PUSH:    state_next = IDLE;
      POP_RD:  state_next = POP_CAP;
      POP_CAP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    case (state_reg)
      PUSH: begin
        mem_we    = 1'b1;
        mem_addr  = sp_reg;
        mem_wdata = data_reg;
      end
      POP_RD: begin
        mem_re   = 1'b1;
        mem_addr = sp_reg;
      end
      default: ;
    endcase
  end

  assign ready     = ready_reg;
  assign pop_data  = pop_data_reg;
  assign pop_valid = pop_valid_reg;
  assign sp        = sp_reg;
  assign count     = used[8:0];
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter STACK_TOP, default 16'h01FF: address of the first (bottom) stack slot and the pointer reset value.
REQ-002 SHALL have parameter DEPTH, default 256: maximum entries; stack grows downward from STACK_TOP to STACK_TOP-DEPTH+1.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 push_req  in  1  push request; level, held by requester until accepted.
REQ-006 push_data  in  16  word to push; sampled on the accept edge.
REQ-007 pop_req  in  1  pop request; level, held until accepted.
REQ-008 clr_err  in  1  synchronous clear of the overflow and underflow flags.
REQ-009 ready  out  1  controller idle; a request is accepted on an edge where req && ready.
REQ-010 pop_data  out  16  popped word, registered.
REQ-011 pop_valid  out  1  one-cycle pulse, pop_data valid.
REQ-012 sp  out  16  current stack pointer, pointing to the next free slot.
REQ-013 count  out  9  number of stored entries = STACK_TOP - sp.
REQ-014 full / empty  out  1 each  count==DEPTH / count==0.
REQ-015 overflow / underflow  out  1 each  sticky error flags.
REQ-016 mem_addr  out  16, mem_we  out  1, mem_re  out  1, mem_wdata  out  16, mem_rdata  in  16  synchronous RAM port; read data valid the cycle after mem_re.

Function
REQ-017 SHALL implement FSM states IDLE, PUSH, POP_RD, POP_CAP; ready=1 only in IDLE with rst low.
REQ-018 IDLE, push_req && !full: latch push_data, go to PUSH.
REQ-019 PUSH: mem_we=1, mem_addr=sp, mem_wdata=latched word for exactly one cycle; sp <= sp-1 at end of cycle; go to IDLE (push = 2 cycles accept-to-ready).
REQ-020 IDLE, pop_req && !empty && !push_req: sp <= sp+1 on accept edge; go to POP_RD.
REQ-021 POP_RD: mem_re=1, mem_addr=sp (incremented value) for exactly one cycle; go to POP_CAP.
REQ-022 POP_CAP: pop_data <= mem_rdata; go to IDLE; pop_valid=1 in the following (IDLE) cycle only.
REQ-023 Simultaneous push_req and pop_req in IDLE: push wins; a held pop is accepted on the next IDLE cycle.
REQ-024 push_req while full in IDLE: not accepted, no memory write, sp unchanged, overflow <= 1, ready stays 1.
REQ-025 pop_req while empty in IDLE: not accepted, no memory read, sp unchanged, underflow <= 1.
REQ-026 When push_req && full && pop_req, the pop SHALL be accepted; overflow SHALL NOT be set.
REQ-027 overflow/underflow SHALL stay set until clr_err or rst; clr_err and a same-cycle new error: the flag SHALL be set (set wins).
REQ-028 mem_we and mem_re SHALL never be high in the same cycle; both SHALL be 0 in IDLE and POP_CAP.
REQ-029 sp arithmetic SHALL be 16-bit; sp SHALL never leave [STACK_TOP-DEPTH, STACK_TOP].
REQ-030 Requests arriving while not in IDLE SHALL be ignored until ready=1.

Reset
REQ-031 On rst high: sp=STACK_TOP, state=IDLE, ready=0, pop_data=0, pop_valid=0, overflow=0, underflow=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, count=0, empty=1, full=0.
REQ-032 rst asserted mid-PUSH or mid-POP SHALL abort the operation immediately; no pop_valid afterwards; sp returns to STACK_TOP.
REQ-033 ready SHALL rise on the first clk edge after rst deasserts.

Verification
REQ-034 Reset then idle -> sp=16'h01FF, count=0, empty=1, ready=1, no mem strobes.
REQ-035 push 16'hA5A5 -> mem_we one cycle at addr 16'h01FF, data 16'hA5A5; sp=16'h01FE, count=1; ready back after 2 cycles.
REQ-036 push 16'h1111, push 16'h2222, pop, pop -> pop_data 16'h2222 then 16'h1111, each with a one-cycle pop_valid; reads at 16'h01FE then 16'h01FF; final sp=16'h01FF, empty=1.
REQ-037 pop when empty -> underflow=1, no mem_re, sp=16'h01FF; clr_err -> underflow=0.
REQ-038 256 pushes -> full=1, sp=16'h00FF; 257th push -> overflow=1, no write; push_req and pop_req together -> pop accepted, sp=16'h0100.
REQ-039 push_req and pop_req together with 1 entry -> push first (sp=16'h01FD), then pop returns the new word; rst asserted in POP_RD -> no pop_valid, sp=16'h01FF.
